// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: services byte/half/word
// loads and stores from an internal word RAM after WAIT_CYCLES wait states.
module data_mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              Done,
    output logic              Fault,
    output logic [1:0]        o_dbg_state
);

    localparam int         DEPTH     = 2 ** (ADDR_W - 2);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT  = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_is_store;
    logic [2:0]        r_f3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_fault;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_commit;
    logic              w_cur_store;
    logic [2:0]        w_cur_f3;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [31:0]       w_cur_wdata;
    logic              w_bad_f3;
    logic              w_misalign;
    logic              w_fault;
    logic [ADDR_W-3:0] w_idx;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_val;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;

    assign w_accept = (r_state == S_IDLE) && (MemRead || MemWrite);

    // In IDLE the live inputs are the request; afterwards only latched copies count.
    assign w_cur_store = (r_state == S_IDLE) ? MemWrite  : r_is_store;
    assign w_cur_f3    = (r_state == S_IDLE) ? Funct3    : r_f3;
    assign w_cur_addr  = (r_state == S_IDLE) ? Addr      : r_addr;
    assign w_cur_wdata = (r_state == S_IDLE) ? WriteData : r_wdata;

    // Commit edge is the one entering DONE; reset low must suppress it.
    assign w_commit = reset && (((r_state == S_WAIT) && (r_cnt == 4'd0)) ||
                                (w_accept && ZERO_WAIT));

    assign w_bad_f3   = (w_cur_f3[1:0] == 2'b11) ||
                        (w_cur_f3[2] && (w_cur_store || w_cur_f3[1]));
    assign w_misalign = ((w_cur_f3[1:0] == 2'b01) && w_cur_addr[0]) ||
                        ((w_cur_f3[1:0] == 2'b10) && (w_cur_addr[1:0] != 2'b00));
    assign w_fault    = w_bad_f3 || w_misalign;

    assign w_idx  = w_cur_addr[ADDR_W-1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_cur_addr[1:0], 3'b000} +: 8];
    assign w_half = w_cur_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_val = w_word;
        w_be       = 4'b1111;
        w_wdata    = w_cur_wdata;
        case (w_cur_f3[1:0])
            2'b00: begin
                w_load_val = {{24{~w_cur_f3[2] & w_byte[7]}}, w_byte};
                w_be       = 4'b0001 << w_cur_addr[1:0];
                w_wdata    = {4{w_cur_wdata[7:0]}};
            end
            2'b01: begin
                w_load_val = {{16{~w_cur_f3[2] & w_half[15]}}, w_half};
                w_be       = w_cur_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{w_cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_is_store <= 1'b0;
            r_f3       <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_fault    <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            if (w_commit && !w_cur_store) begin
                r_rdata <= w_fault ? 32'd0 : w_load_val;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_store <= MemWrite;
                        r_f3       <= Funct3;
                        r_addr     <= Addr;
                        r_wdata    <= WriteData;
                        r_fault    <= w_fault;
                        r_cnt      <= CNT_INIT;
                        r_state    <= ZERO_WAIT ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM has no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_cur_store && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign Stall       = w_accept || (r_state == S_WAIT);
    assign Done        = (r_state == S_DONE);
    assign Fault       = Done && r_fault;
    assign ReadData    = r_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) checked
// against a byte-addressed reference memory model.
module tb_data_mem_responder;

  localparam int AW = 9;

  typedef struct {
    bit          r;
    bit          wr;
    logic [2:0]  f;
    logic [8:0]  a;
    logic [31:0] d;
    bit          k_en;
    logic [31:0] k;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mr [2];
  logic        mw [2];
  logic [2:0]  f3 [2];
  logic [AW-1:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        done [2];
  logic        fault [2];
  logic [1:0]  dbg [2];

  logic [7:0]  m_mem [2][512];
  logic [31:0] m_rd [2];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .MemRead(mr[0]), .MemWrite(mw[0]), .Funct3(f3[0]),
    .Addr(ad[0]), .WriteData(wd[0]), .ReadData(rdata[0]), .Stall(stall[0]),
    .Done(done[0]), .Fault(fault[0]), .o_dbg_state(dbg[0])
  );

  data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .MemRead(mr[1]), .MemWrite(mw[1]), .Funct3(f3[1]),
    .Addr(ad[1]), .WriteData(wd[1]), .ReadData(rdata[1]), .Stall(stall[1]),
    .Done(done[1]), .Fault(fault[1]), .o_dbg_state(dbg[1])
  );

  function automatic int wc(input int w);
    return (w == 0) ? 2 : 0;
  endfunction

  function automatic op_t mk(input bit r, input bit wr, input logic [2:0] f, input logic [8:0] a,
                             input logic [31:0] d, input bit k_en, input logic [31:0] k);
    op_t o;
    o.r = r; o.wr = wr; o.f = f; o.a = a; o.d = d; o.k_en = k_en; o.k = k;
    return o;
  endfunction

  // Reference: byte-addressed little-endian memory, size = 2^Funct3[1:0] bytes.
  task automatic model_access(input int w, input op_t o, output logic flt, output logic [31:0] rd);
    int size;
    int base;
    logic [31:0] v;
    size = 1 << o.f[1:0];
    base = int'(o.a);
    flt = (size == 8) || (o.f[2] && (o.wr || size == 4)) || ((base % size) != 0);
    if (!flt && o.wr) begin
      for (int i = 0; i < size; i++) m_mem[w][base + i] = o.d[8*i +: 8];
    end
    if (!o.wr) begin
      if (flt) begin
        m_rd[w] = 32'd0;
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = m_mem[w][base + i];
        if (!o.f[2] && size < 4 && v[8*size - 1]) v = v | (32'hFFFF_FFFF << (8*size));
        m_rd[w] = v;
      end
    end
    rd = m_rd[w];
  endtask

  task automatic idle_inputs(input int w);
    mr[w] = 1'b0; mw[w] = 1'b0; f3[w] = 3'd0; ad[w] = '0; wd[w] = 32'd0;
  endtask

  task automatic junk_inputs(input int w);
    mr[w] = 1'($urandom_range(0, 1));
    mw[w] = 1'($urandom_range(0, 1));
    f3[w] = 3'($urandom_range(0, 7));
    ad[w] = 9'($urandom_range(0, 511));
    wd[w] = $urandom;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after DONE.
  task automatic drive_access(input int w, input op_t o, output int stall_n, output int lat,
                              output logic flt, output logic [31:0] rdv, output int done_cyc);
    mr[w] = o.r; mw[w] = o.wr; f3[w] = o.f; ad[w] = o.a; wd[w] = o.d;
    stall_n = 0; lat = -1; flt = 1'b0; rdv = 32'd0; done_cyc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (stall[w]) stall_n++;
      if (done[w]) begin
        lat = n; flt = fault[w]; rdv = rdata[w]; done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      junk_inputs(w);
    end
    @(posedge clk); #1;
    idle_inputs(w);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int w = 0; w < 2; w++) idle_inputs(w);
    #12;
    for (int w = 0; w < 2; w++) begin
      checks++; if (stall[w] !== 1'b0) begin errors++; $display("FAIL reset[%0d] stall got=%b exp=0", w, stall[w]); end
      checks++; if (done[w] !== 1'b0) begin errors++; $display("FAIL reset[%0d] done got=%b exp=0", w, done[w]); end
      checks++; if (fault[w] !== 1'b0) begin errors++; $display("FAIL reset[%0d] fault got=%b exp=0", w, fault[w]); end
      checks++; if (rdata[w] !== 32'd0) begin errors++; $display("FAIL reset[%0d] rdata got=%h exp=0", w, rdata[w]); end
      m_rd[w] = 32'd0;
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic fill_memory(input int w);
    int sn, lat, dc;
    logic flt, eflt;
    logic [31:0] rdv, erd;
    op_t o;
    for (int i = 0; i < 128; i++) begin
      o = mk(0, 1, 3'b010, 9'(i * 4), $urandom, 0, 0);
      drive_access(w, o, sn, lat, flt, rdv, dc);
      model_access(w, o, eflt, erd);
    end
  endtask

  task automatic run_directed(input string name, input int w, input op_t ops[$]);
    int sn, lat, dc;
    logic flt, eflt;
    logic [31:0] rdv, erd;
    foreach (ops[i]) begin
      drive_access(w, ops[i], sn, lat, flt, rdv, dc);
      model_access(w, ops[i], eflt, erd);
      checks++; if (sn !== wc(w) + 1) begin errors++; $display("FAIL %s[%0d] stall_cycles got=%0d exp=%0d", name, i, sn, wc(w) + 1); end
      checks++; if (lat !== wc(w) + 1) begin errors++; $display("FAIL %s[%0d] done_latency got=%0d exp=%0d", name, i, lat, wc(w) + 1); end
      checks++; if (flt !== eflt) begin errors++; $display("FAIL %s[%0d] fault got=%b exp=%b", name, i, flt, eflt); end
      checks++; if (rdv !== erd) begin errors++; $display("FAIL %s[%0d] rdata got=%h exp=%h", name, i, rdv, erd); end
      if (ops[i].k_en) begin
        checks++; if (rdv !== ops[i].k) begin errors++; $display("FAIL %s[%0d] rdata_const got=%h exp=%h", name, i, rdv, ops[i].k); end
      end
    end
  endtask

  task automatic test_word_roundtrip();
    op_t ops[$];
    ops.push_back(mk(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 0, 0));
    ops.push_back(mk(1, 0, 3'b010, 9'h010, 32'h0, 1, 32'hDEADBEEF));
    run_directed("roundtrip", 0, ops);
  endtask

  task automatic test_subword();
    op_t ops[$];
    ops.push_back(mk(0, 1, 3'b010, 9'h020, 32'h0, 1, 32'hDEADBEEF));
    ops.push_back(mk(0, 1, 3'b000, 9'h021, 32'h0000_0080, 0, 0));
    ops.push_back(mk(1, 0, 3'b010, 9'h020, 32'h0, 1, 32'h0000_8000));
    ops.push_back(mk(1, 0, 3'b000, 9'h021, 32'h0, 1, 32'hFFFF_FF80));
    ops.push_back(mk(1, 0, 3'b100, 9'h021, 32'h0, 1, 32'h0000_0080));
    ops.push_back(mk(0, 1, 3'b001, 9'h022, 32'h0000_ABCD, 0, 0));
    ops.push_back(mk(1, 0, 3'b101, 9'h022, 32'h0, 1, 32'h0000_ABCD));
    ops.push_back(mk(1, 0, 3'b001, 9'h022, 32'h0, 1, 32'hFFFF_ABCD));
    run_directed("subword", 0, ops);
  endtask

  task automatic test_misalign();
    op_t ops[$];
    ops.push_back(mk(1, 0, 3'b010, 9'h013, 32'h0, 1, 32'h0));
    ops.push_back(mk(0, 1, 3'b010, 9'h030, 32'hCAFEF00D, 1, 32'h0));
    ops.push_back(mk(0, 1, 3'b001, 9'h031, 32'h0000_1234, 1, 32'h0));
    ops.push_back(mk(1, 0, 3'b010, 9'h030, 32'h0, 1, 32'hCAFEF00D));
    ops.push_back(mk(1, 0, 3'b110, 9'h030, 32'h0, 1, 32'h0));
    ops.push_back(mk(0, 1, 3'b100, 9'h030, 32'hFFFF_FFFF, 1, 32'h0));
    ops.push_back(mk(1, 0, 3'b010, 9'h030, 32'h0, 1, 32'hCAFEF00D));
    run_directed("misalign", 0, ops);
  endtask

  task automatic test_simultaneous();
    op_t ops[$];
    ops.push_back(mk(1, 1, 3'b010, 9'h050, 32'h5A5A5A5A, 1, 32'hCAFEF00D));
    ops.push_back(mk(1, 0, 3'b010, 9'h050, 32'h0, 1, 32'h5A5A5A5A));
    run_directed("simultaneous", 0, ops);
  endtask

  task automatic test_reset_mid_store();
    op_t ops[$];
    ops.push_back(mk(0, 1, 3'b010, 9'h040, 32'h11111111, 0, 0));
    run_directed("pre_reset", 0, ops);
    mr[0] = 1'b0; mw[0] = 1'b1; f3[0] = 3'b010; ad[0] = 9'h040; wd[0] = 32'h12345678;
    @(posedge clk); #1;
    idle_inputs(0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      checks++; if (stall[w] !== 1'b0) begin errors++; $display("FAIL mid_reset[%0d] stall got=%b exp=0", w, stall[w]); end
      checks++; if (done[w] !== 1'b0) begin errors++; $display("FAIL mid_reset[%0d] done got=%b exp=0", w, done[w]); end
      checks++; if (fault[w] !== 1'b0) begin errors++; $display("FAIL mid_reset[%0d] fault got=%b exp=0", w, fault[w]); end
      checks++; if (rdata[w] !== 32'd0) begin errors++; $display("FAIL mid_reset[%0d] rdata got=%h exp=0", w, rdata[w]); end
      m_rd[w] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    ops.delete();
    ops.push_back(mk(1, 0, 3'b010, 9'h040, 32'h0, 1, 32'h11111111));
    run_directed("post_reset", 0, ops);
  endtask

  task automatic test_back_to_back(input int w, input int count);
    int sn, lat, dc, prev_dc;
    logic flt, eflt;
    logic [31:0] rdv, erd;
    op_t o;
    prev_dc = -1;
    for (int i = 0; i < count; i++) begin
      o = mk(1, 0, 3'($urandom_range(0, 2)), 9'($urandom_range(0, 127) * 4), 32'h0, 0, 0);
      if (i % 3 == 1) begin o.r = 1'b0; o.wr = 1'b1; o.d = $urandom; end
      drive_access(w, o, sn, lat, flt, rdv, dc);
      model_access(w, o, eflt, erd);
      checks++; if (sn !== wc(w) + 1) begin errors++; $display("FAIL b2b%0d[%0d] stall_cycles got=%0d exp=%0d", w, i, sn, wc(w) + 1); end
      checks++; if (rdv !== erd) begin errors++; $display("FAIL b2b%0d[%0d] rdata got=%h exp=%h", w, i, rdv, erd); end
      if (i > 0) begin
        checks++; if (dc - prev_dc !== wc(w) + 2) begin errors++; $display("FAIL b2b%0d[%0d] done_spacing got=%0d exp=%0d", w, i, dc - prev_dc, wc(w) + 2); end
      end
      prev_dc = dc;
    end
  endtask

  task automatic test_random(input int w, input int count);
    int sn, lat, dc, size;
    logic flt, eflt;
    logic [31:0] rdv, erd;
    op_t o;
    for (int i = 0; i < count; i++) begin
      o.r = 1'($urandom_range(0, 1));
      o.wr = o.r ? 1'($urandom_range(0, 1)) : 1'b1;
      o.f = 3'($urandom_range(0, 7));
      o.a = 9'($urandom_range(0, 511));
      size = 1 << o.f[1:0];
      if ($urandom_range(0, 3) != 0) o.a = 9'(int'(o.a) & ~(size - 1));
      o.d = $urandom;
      o.k_en = 1'b0; o.k = 32'd0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      drive_access(w, o, sn, lat, flt, rdv, dc);
      model_access(w, o, eflt, erd);
      checks++; if (sn !== wc(w) + 1) begin errors++; $display("FAIL rand%0d[%0d] stall_cycles got=%0d exp=%0d", w, i, sn, wc(w) + 1); end
      checks++; if (lat !== wc(w) + 1) begin errors++; $display("FAIL rand%0d[%0d] done_latency got=%0d exp=%0d", w, i, lat, wc(w) + 1); end
      checks++; if (flt !== eflt) begin errors++; $display("FAIL rand%0d[%0d] fault got=%b exp=%b f3=%b a=%h", w, i, flt, eflt, o.f, o.a); end
      checks++; if (rdv !== erd) begin errors++; $display("FAIL rand%0d[%0d] rdata got=%h exp=%h f3=%b a=%h", w, i, rdv, erd, o.f, o.a); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    fill_memory(0);
    fill_memory(1);
    test_word_roundtrip();
    test_subword();
    test_misalign();
    test_simultaneous();
    test_reset_mid_store();
    test_back_to_back(0, 8);
    test_back_to_back(1, 8);
    test_random(0, 80);
    test_random(1, 80);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the RISC-V core's MEM stage. It accepts the load/store requests the main controller raises through MemRead/MemWrite, and services them from an internal word-organised RAM after a configurable wait-state latency. It supports byte, half and word sizes with sign- or zero-extension. While an access is in flight it freezes the pipeline through Stall.

## Interface
- ADDR_W, 9: byte-address width. The RAM holds 2^(ADDR_W-2) 32-bit words.
- WAIT_CYCLES, 2: wait states per access. Legal range 0..15.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- MemRead  in  1  load request from the controller
- MemWrite  in  1  store request from the controller
- Funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- Addr  in  ADDR_W  byte address (ALU result)
- WriteData  in  32  store data; the low bytes are used for SB/SH
- ReadData  out  32  extended load result; registered
- Stall  out  1  pipeline freeze; combinational
- Done  out  1  one-cycle completion pulse; registered state
- Fault  out  1  access rejected; valid only while Done=1

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - When MemRead|MemWrite=1: latch Addr, WriteData, Funct3 and the op, and set Stall=1 in the same cycle.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise DONE.
- **WAIT**
  - A 4-bit counter is loaded with WAIT_CYCLES-1 on entry and decrements each cycle.
  - Stall=1 throughout. Go to DONE when the counter reaches 0.
- **DONE**
  - Stall=0 and Done=1; the pipeline advances at the end of this cycle.
  - Request inputs are ignored in this cycle because they still belong to the finishing instruction.
  - Always return to IDLE.
- MemRead and MemWrite both high: the request is treated as a store.
- Fault conditions, checked on the latched request:
  - Funct3 is 011, 110 or 111, or any store Funct3 above 010;
  - halfword access with Addr[0]=1;
  - word access with Addr[1:0]≠00.
- On a fault:
  - no RAM write occurs;
  - ReadData becomes 0;
  - full latency still applies;
  - Fault=1 in DONE.
- Store lane mapping:
  - SB writes the lane at Addr[1:0] with WriteData[7:0];
  - SH writes lanes {Addr[1],0} and {Addr[1],1} with WriteData[15:0];
  - SW writes all lanes. Other lanes are unchanged.
- Load extraction:
  - the selected byte or half is right-justified;
  - LB/LH sign-extend from bit 7/15;
  - LBU/LHU zero-extend.
- Word index is Addr[ADDR_W-1:2]. There are no out-of-range addresses.
- RAM contents are not cleared by reset.

## Timing
- Reset values: state IDLE, counter 0, Stall 0, Done 0, Fault 0, ReadData 0.
- Request seen in IDLE at cycle T:
  - WAIT occupies T+1..T+WAIT_CYCLES;
  - DONE occurs at T+WAIT_CYCLES+1;
  - Stall is high for exactly WAIT_CYCLES+1 cycles (T..T+WAIT_CYCLES).
- Store commit: the RAM write happens at the clock edge entering DONE. A load issued in the very next request sees the new data.
- ReadData:
  - updated at the edge entering DONE for loads (and cleared to 0 for faulted loads);
  - held unchanged through stores and idle cycles until the next load completes.
- Back-to-back requests: the earliest next acceptance is the cycle after DONE, so the minimum spacing between Done pulses is WAIT_CYCLES+2 cycles.
- Reset asserted mid-access:
  - takes effect immediately (asynchronous), aborts the access and returns all outputs to their reset values;
  - a store that has not yet reached its commit edge is not written.
- Request inputs that change during WAIT have no effect, since only latched values are used.

## Test plan
- **Word round-trip**, WAIT_CYCLES=2: SW 0xDEADBEEF to Addr 0x010, then LW from 0x010 → Stall high for 3 cycles each time, Done on the 4th cycle, ReadData=0xDEADBEEF, Fault=0.
- **Sub-word stores and loads**:
  - SB 0x80 to 0x021 over a word of 0 → LW 0x020 returns 0x00008000;
  - LB 0x021 returns 0xFFFFFF80;
  - LBU 0x021 returns 0x00000080;
  - SH 0xABCD to 0x022, then LHU 0x022 → 0x0000ABCD.
- **Misalignment**:
  - LW 0x013 → Fault=1 with Done, ReadData=0, latency unchanged;
  - SH 0x031 → Fault=1, and a following LW 0x030 shows the word unchanged.
- **Zero wait states**, WAIT_CYCLES=0: a load in IDLE gives Stall=1 for one cycle and Done the next. Back-to-back loads show Done pulses 2 cycles apart.
- **Reset mid-store**: assert reset during WAIT of SW 0x12345678 to 0x040 (word previously 0x11111111) → outputs go to 0 immediately; a later LW 0x040 returns 0x11111111.
- **Simultaneous MemRead=MemWrite=1** with SW data 0x5A5A5A5A at 0x050 → treated as a store; ReadData is unchanged and a subsequent LW returns 0x5A5A5A5A.
